// File: rtl/pa_fpu_src_cls_pipe_pkg.sv
// Shared definitions for the FP source classifier: format codes, fclass bit
// indices and the field-level classify helper.
package pa_fpu_src_cls_pipe_pkg;

  typedef enum logic [1:0] {
    FMT_S = 2'b00,
    FMT_D = 2'b01,
    FMT_H = 2'b10,
    FMT_R = 2'b11
  } fmt_e;

  localparam int CLS_W    = 10;
  localparam int CLS_NINF = 0;
  localparam int CLS_NNRM = 1;
  localparam int CLS_NSUB = 2;
  localparam int CLS_NZER = 3;
  localparam int CLS_PZER = 4;
  localparam int CLS_PSUB = 5;
  localparam int CLS_PNRM = 6;
  localparam int CLS_PINF = 7;
  localparam int CLS_SNAN = 8;
  localparam int CLS_QNAN = 9;

  localparam logic [CLS_W-1:0] CLS_QNAN_ONEHOT = 10'h200;

  // Field-level classification, shared by every format once fields are extracted.
  function automatic logic [CLS_W-1:0] classify(input logic sign, input logic exp_zero,
                                                input logic exp_ones, input logic frac_zero,
                                                input logic frac_msb);
    logic [CLS_W-1:0] c;
    c = '0;
    if (exp_ones) begin
      if (frac_zero) c[sign ? CLS_NINF : CLS_PINF] = 1'b1;
      else           c[frac_msb ? CLS_QNAN : CLS_SNAN] = 1'b1;
    end else if (exp_zero) begin
      if (frac_zero) c[sign ? CLS_NZER : CLS_PZER] = 1'b1;
      else           c[sign ? CLS_NSUB : CLS_PSUB] = 1'b1;
    end else begin
      c[sign ? CLS_NNRM : CLS_PNRM] = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pa_fpu_cls_unit.sv
// Combinational single-operand classifier: NaN-box check plus RISC-V fclass one-hot.
module pa_fpu_cls_unit
  import pa_fpu_src_cls_pipe_pkg::*;
#(
  parameter int FLEN = 64
) (
  input  logic [1:0]       fmt,
  input  logic [FLEN-1:0]  src,
  input  logic             use_op,
  output logic [CLS_W-1:0] cls,
  output logic             cnan
);

  // Bits above FLEN do not exist; the mask makes them count as boxed.
  localparam logic [63:0] LIVE = (FLEN == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;

  logic [63:0] src64;
  logic        box_s;
  logic        box_h;

  assign src64 = 64'(src);
  assign box_s = &(src64[63:32] | ~LIVE[63:32]);
  assign box_h = &(src64[63:16] | ~LIVE[63:16]);

  // Per-format field extraction and classification.
  always_comb begin
    cls  = '0;
    cnan = 1'b0;
    if (!use_op) begin
      cls  = '0;
      cnan = 1'b0;
    end else begin
      case (fmt_e'(fmt))
        FMT_S: begin
          if (box_s) begin
            cls = classify(src64[31], src64[30:23] == 8'h00, &src64[30:23],
                           src64[22:0] == 23'h0, src64[22]);
          end else begin
            cls  = CLS_QNAN_ONEHOT;
            cnan = 1'b1;
          end
        end
        FMT_D: begin
          if (FLEN == 64) begin
            cls = classify(src64[63], src64[62:52] == 11'h000, &src64[62:52],
                           src64[51:0] == 52'h0, src64[51]);
          end else begin
            cls = '0;
          end
        end
        FMT_H: begin
          if (box_h) begin
            cls = classify(src64[15], src64[14:10] == 5'h00, &src64[14:10],
                           src64[9:0] == 10'h000, src64[9]);
          end else begin
            cls  = CLS_QNAN_ONEHOT;
            cnan = 1'b1;
          end
        end
        default: cls = '0;
      endcase
    end
  end

endmodule

// File: rtl/pa_fpu_src_cls_pipe.sv
// Multi-operand FP source classifier with a one-cycle valid/ready stage
// (output register plus one skid entry, registered in_rdy).
module pa_fpu_src_cls_pipe
  import pa_fpu_src_cls_pipe_pkg::*;
#(
  parameter int FLEN    = 64,
  parameter int NUM_SRC = 3
) (
  input  logic                      cpuclk,
  input  logic                      cpurst_b,
  input  logic                      flush,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic [1:0]                in_fmt,
  input  logic [NUM_SRC-1:0]        in_src_mask,
  input  logic [NUM_SRC*FLEN-1:0]   in_src,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic [NUM_SRC*CLS_W-1:0]  out_cls,
  output logic [NUM_SRC-1:0]        out_cnan,
  output logic                      out_any_snan,
  output logic                      out_any_nan,
  output logic                      out_fmt_illegal
);

  localparam int CW = NUM_SRC * CLS_W;
  localparam int EW = CW + NUM_SRC + 3;

  logic [CW-1:0]      cls_c;
  logic [NUM_SRC-1:0] cnan_c;
  logic               any_snan_c;
  logic               any_nan_c;
  logic               ill_c;
  logic [EW-1:0]      new_entry;
  logic [EW-1:0]      out_q;
  logic [EW-1:0]      skid_q;
  logic               skid_vld;
  logic               push;
  logic               pop;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_cls
    pa_fpu_cls_unit #(.FLEN(FLEN)) u_cls (
      .fmt    (in_fmt),
      .src    (in_src[i*FLEN +: FLEN]),
      .use_op (in_src_mask[i]),
      .cls    (cls_c[i*CLS_W +: CLS_W]),
      .cnan   (cnan_c[i])
    );
  end

  // Aggregate NaN flags; unmasked operands already classify as zero.
  always_comb begin
    any_snan_c = 1'b0;
    any_nan_c  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      any_snan_c = any_snan_c | cls_c[i*CLS_W + CLS_SNAN];
      any_nan_c  = any_nan_c | cls_c[i*CLS_W + CLS_SNAN] | cls_c[i*CLS_W + CLS_QNAN];
    end
  end

  assign ill_c     = (fmt_e'(in_fmt) == FMT_R) || ((fmt_e'(in_fmt) == FMT_D) && (FLEN != 64));
  assign new_entry = {ill_c, any_nan_c, any_snan_c, cnan_c, cls_c};

  // in_rdy comes straight from the skid flop, so out_rdy never reaches it combinationally.
  assign in_rdy = ~skid_vld;
  assign push   = in_vld & in_rdy;
  assign pop    = out_vld & out_rdy;

  // Output register and skid entry; flush empties both and drops any same-cycle push.
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
    end else if (!out_vld || pop) begin
      if (skid_vld) begin
        out_q    <= skid_q;
        out_vld  <= 1'b1;
        skid_vld <= 1'b0;
      end else if (push) begin
        out_q   <= new_entry;
        out_vld <= 1'b1;
      end else begin
        out_vld <= 1'b0;
      end
    end else if (push) begin
      skid_q   <= new_entry;
      skid_vld <= 1'b1;
    end
  end

  assign out_cls         = out_q[CW-1:0];
  assign out_cnan        = out_q[CW +: NUM_SRC];
  assign out_any_snan    = out_q[CW + NUM_SRC];
  assign out_any_nan     = out_q[CW + NUM_SRC + 1];
  assign out_fmt_illegal = out_q[CW + NUM_SRC + 2];

endmodule
